weight_loader: RTL and testbench
================================

// Module: weight_loader
// PURPOSE
//  Upstream feeder for the per-column weight accumulators ahead of the systolic array.
//  On a start pulse it reads one weight tile (WEIGHT_ACC_WIDTH rows x SYSTOLIC_ARRAY_WIDTH cols)
//  from the unified buffer and enqueues it into every column's weight accumulator.
//  It then issues column-skewed dequeue strobes so weights enter the array diagonally.
// PARAMETERS
//  SYSTOLIC_ARRAY_WIDTH  2  N: number of columns / weight accumulators driven
//  WEIGHT_ACC_WIDTH      4  D: tile rows = accumulator depth
//  ADDR_WIDTH            8  unified-buffer row address width
// PORTS
//  clk                  in   1        single clock, rising edge
//  rst                  in   1        synchronous, active-high reset
//  start                in   1        begin tile load; sampled only in IDLE
//  base_addr            in   ADDR_W   tile row 0 address; latched when start accepted
//  busy                 out  1        high in every state except IDLE
//  done                 out  1        one-cycle pulse after the last dequeue strobe
//  ub_rd_en             out  1        unified-buffer row read request
//  ub_rd_addr           out  ADDR_W   row address; valid while ub_rd_en
//  ub_rd_data           in   N x 16   signed row; valid exactly 1 cycle after ub_rd_en
//  wacc_valid_data_out  out  N        enqueue strobe per column
//  wacc_data_out        out  N x 16   signed enqueue data per column
//  wacc_valid_out       out  N        dequeue strobe per column (skewed)
// BEHAVIOUR
//  - Reset: every output 0 (busy, done, ub_rd_en, ub_rd_addr, all wacc_* buses); FSM -> IDLE.
//  - Registered outputs; no combinational input->output paths.
//  - FSM: IDLE -> FETCH -> FILL -> STREAM -> DONE -> IDLE.
//  - Timeline, start=1 sampled in IDLE at cycle T:
//    FETCH  T+1..T+D: ub_rd_en=1, ub_rd_addr=base+k for k=0..D-1, mod 2^ADDR_WIDTH (wraps).
//    ub_rd_data registered: wacc_valid_data_out = all-ones at T+3..T+D+2.
//    At those cycles, wacc_data_out[c] = row k col c.
//    FILL covers the cycles between the last read and the last enqueue.
//    STREAM: column c has wacc_valid_out[c]=1 at T+D+3+c .. T+2D+2+c (D cycles each).
//    Dequeue strobes come from a 1-per-column delay chain.
//    DONE: done=1 for one cycle at T+2D+N+2; busy=1 from T+1 through T+2D+N+2.
//  - Next start is accepted no earlier than T+2D+N+3.
//  - For any column, enqueue and dequeue strobes are never high in the same cycle.
//    Downstream gives enqueue priority, so overlap would drop a dequeue.
//  - wacc_data_out = 0 whenever wacc_valid_data_out = 0.
//  - start while busy (any non-IDLE state, incl. DONE): ignored; base_addr not re-latched.
//  - rst mid-operation: immediate return to IDLE with all outputs 0 the next cycle.
//    No done pulse; partially enqueued accumulators are also reset by the shared rst.
//  - Counters sized $clog2(D+N)+1; row counter wraps only via FSM exit, never free-runs.
// STRUCTURE
//  - Shared package: DATA_WIDTH=16, the signed 16-bit weight typedef, and the FSM state enum.
//  - Sub-module: valid_skew_chain (N-stage shift register).
//    Input: a D-cycle column-0 dequeue pulse. Output: wacc_valid_out[N-1:0], tap c delayed by c.
//  - Remainder (FSM, address/row counters, read-data register) lives in weight_loader.
// TESTING  (N=2, D=4 unless stated; mem[a] = {col1=a*2+1, col0=a*2})
//  - Reset: hold rst 3 cycles with start=1 -> all outputs 0, busy=0, no ub_rd_en.
//  - Basic tile: base=0x10, start@T -> ub_rd_addr 0x10..0x13 at T+1..T+4.
//    Enqueue col0 = 0x20,0x22,0x24,0x26 at T+3..T+6.
//    wacc_valid_out[0] high T+7..T+10, [1] high T+8..T+11; done at T+12.
//  - Wrap: base=0xFE -> addresses 0xFE,0xFF,0x00,0x01; data follows mem contents.
//  - Start while busy: pulse start at T+5 with base=0x40 -> ignored; addresses unchanged.
//    Single done at T+12.
//  - Reset mid-stream: rst at T+8 -> T+9 all outputs 0, busy=0, no done.
//    A fresh start at T+10 completes normally.
//  - Back-to-back + scaling: start at T+13 after first done -> second tile timeline identical.
//    Repeat with N=4, D=2: skew of 0..3 cycles; done at T+2D+N+2 = T+10.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg: shared weight type, data width and loader FSM states
package weight_loader_pkg;
  localparam int DATA_WIDTH = 16;
  typedef logic signed [DATA_WIDTH-1:0] weight_t;
  typedef enum logic [2:0] {IDLE, FETCH, FILL, STREAM, DONE} state_e;
endpackage

// File: rtl/weight_loader_valid_skew_chain.sv
// valid_skew_chain: shift register turning one column-0 dequeue pulse into per-column strobes delayed by column index
module valid_skew_chain #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pulse_i,
  output logic [N-1:0] valid_o
);
  logic [N-1:0] sr_q;
  always_ff @(posedge clk) sr_q <= rst ? '0 : (sr_q << 1) | N'(pulse_i);
  assign valid_o = sr_q;
endmodule

// File: rtl/weight_loader.sv
// weight_loader: fetches one weight tile from the unified buffer, enqueues it into every column accumulator, then issues skewed dequeue strobes
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int WEIGHT_ACC_WIDTH     = 4,
  parameter int ADDR_WIDTH           = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 ub_rd_en,
  output logic [ADDR_WIDTH-1:0]                ub_rd_addr,
  input  weight_t [SYSTOLIC_ARRAY_WIDTH-1:0]   ub_rd_data,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]      wacc_valid_data_out,
  output weight_t [SYSTOLIC_ARRAY_WIDTH-1:0]   wacc_data_out,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]      wacc_valid_out
);
  localparam int N  = SYSTOLIC_ARRAY_WIDTH;
  localparam int D  = WEIGHT_ACC_WIDTH;
  localparam int CW = $clog2(D + N) + 1;
  localparam logic [CW-1:0] FETCH_LAST  = CW'(D - 1);
  localparam logic [CW-1:0] FILL_LAST   = CW'(1);
  localparam logic [CW-1:0] STREAM_LAST = CW'(D + N - 2);
  localparam logic [CW-1:0] DEQ_END     = CW'(D - 1);
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_en_q, rd_vld_q, busy_q, done_q, deq0;
  logic [N-1:0]          enq_q;
  weight_t [N-1:0]       data_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = FETCH;
      end
      FETCH: if (cnt_q == FETCH_LAST) begin
        state_d = FILL;
        cnt_d   = '0;
      end
      FILL: if (cnt_q == FILL_LAST) begin
        state_d = STREAM;
        cnt_d   = '0;
      end
      STREAM: if (cnt_q == STREAM_LAST) begin
        state_d = DONE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  assign addr_d = (state_q == IDLE && start) ? base_addr
                : (state_q == FETCH && state_d == FETCH) ? addr_q + ADDR_WIDTH'(1) : addr_q;
  assign deq0 = (state_q == FILL && cnt_q == FILL_LAST) || (state_q == STREAM && cnt_q < DEQ_END);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      enq_q    <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rd_en_q  <= state_d == FETCH;
      rd_vld_q <= rd_en_q;
      enq_q    <= {N{rd_vld_q}};
      data_q   <= rd_vld_q ? ub_rd_data : '0;
      busy_q   <= state_d != IDLE;
      done_q   <= state_d == DONE;
    end
  end
  valid_skew_chain #(.N(N)) u_skew (
    .clk     (clk),
    .rst     (rst),
    .pulse_i (deq0),
    .valid_o (wacc_valid_out)
  );
  assign busy                = busy_q;
  assign done                = done_q;
  assign ub_rd_en            = rd_en_q;
  assign ub_rd_addr          = addr_q;
  assign wacc_valid_data_out = enq_q;
  assign wacc_data_out       = data_q;
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: scoreboard bench for weight_loader with N=2/D=4 and N=4/D=2 instances
module tb_weight_loader;
  typedef struct {
    int          cyc;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [7:0]  addr;
    logic [3:0]  enq;
    logic [63:0] data;
    logic [3:0]  deq;
  } snap_t;
  logic        clk;
  logic        rst_a, rst_b, start_a, start_b, chk_en;
  logic [7:0]  base_a, base_b, addr_a, addr_b;
  logic        busy_a, busy_b, done_a, done_b, rd_en_a, rd_en_b;
  logic [31:0] rd_data_a, data_a;
  logic [63:0] rd_data_b, data_b;
  logic [1:0]  enq_a, deq_a;
  logic [3:0]  enq_b, deq_b;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  snap_t       sb_a[$];
  snap_t       sb_b[$];
  weight_loader #(.SYSTOLIC_ARRAY_WIDTH(2), .WEIGHT_ACC_WIDTH(4), .ADDR_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .base_addr(base_a), .busy(busy_a), .done(done_a),
    .ub_rd_en(rd_en_a), .ub_rd_addr(addr_a), .ub_rd_data(rd_data_a),
    .wacc_valid_data_out(enq_a), .wacc_data_out(data_a), .wacc_valid_out(deq_a)
  );
  weight_loader #(.SYSTOLIC_ARRAY_WIDTH(4), .WEIGHT_ACC_WIDTH(2), .ADDR_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .base_addr(base_b), .busy(busy_b), .done(done_b),
    .ub_rd_en(rd_en_b), .ub_rd_addr(addr_b), .ub_rd_data(rd_data_b),
    .wacc_valid_data_out(enq_b), .wacc_data_out(data_b), .wacc_valid_out(deq_b)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] row(input int n, input logic [7:0] a);
    logic [63:0] r = '0;
    for (int c = 0; c < n; c++) r[c*16 +: 16] = 16'(int'(a) * n + c);
    return r;
  endfunction
  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? 32'(row(2, addr_a)) : {2{16'hDEAD}};
    rd_data_b <= rd_en_b ? row(4, addr_b) : {4{16'hDEAD}};
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic push_tile(input int inst, input logic [7:0] base);
    int    n, d;
    snap_t s;
    n = inst == 0 ? 2 : 4;
    d = inst == 0 ? 4 : 2;
    for (int r = 1; r <= 2 * d + n + 2; r++) begin
      s       = '{default: '0};
      s.cyc   = cyc + r;
      s.busy  = 1'b1;
      s.done  = r == 2 * d + n + 2;
      s.rd_en = r <= d;
      s.addr  = 8'(int'(base) + r - 1);
      if (r >= 3 && r <= d + 2) begin
        s.enq  = 4'((1 << n) - 1);
        s.data = row(n, 8'(int'(base) + r - 3));
      end
      for (int c = 0; c < n; c++) s.deq[c] = r >= d + 3 + c && r <= 2 * d + 2 + c;
      if (inst == 0) sb_a.push_back(s);
      else sb_b.push_back(s);
    end
  endtask
  task automatic kick(input int inst, input logic [7:0] base);
    if (inst == 0) begin
      start_a = 1'b1;
      base_a  = base;
    end else begin
      start_b = 1'b1;
      base_b  = base;
    end
    push_tile(inst, base);
    step(1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask
  task automatic mon(input string p, input snap_t e, input logic busy, input logic done,
                     input logic rd_en, input logic [7:0] addr, input logic [3:0] enq,
                     input logic [63:0] data, input logic [3:0] deq);
    check({p, "busy"}, 64'(busy), 64'(e.busy));
    check({p, "done"}, 64'(done), 64'(e.done));
    check({p, "rd_en"}, 64'(rd_en), 64'(e.rd_en));
    if (e.rd_en) check({p, "rd_addr"}, 64'(addr), 64'(e.addr));
    check({p, "enq"}, 64'(enq), 64'(e.enq));
    check({p, "enq_data"}, data, e.data);
    check({p, "deq"}, 64'(deq), 64'(e.deq));
  endtask
  always @(negedge clk) begin : monitor
    snap_t ea, eb;
    if (chk_en) begin
      ea = '{default: '0};
      eb = '{default: '0};
      if (sb_a.size() > 0 && sb_a[0].cyc == cyc) ea = sb_a.pop_front();
      if (sb_b.size() > 0 && sb_b[0].cyc == cyc) eb = sb_b.pop_front();
      mon("a_", ea, busy_a, done_a, rd_en_a, addr_a, {2'b0, enq_a}, {32'b0, data_a}, {2'b0, deq_a});
      mon("b_", eb, busy_b, done_b, rd_en_b, addr_b, enq_b, data_b, deq_b);
    end
  end
  initial begin
    chk_en  = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
  end
  initial begin
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    base_a  = 8'h55;
    base_b  = 8'h55;
    step(3);
    check("rst_addr_a", 64'(addr_a), 64'd0);
    check("rst_addr_b", 64'(addr_b), 64'd0);
    rst_a   = 1'b0;
    rst_b   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    step(2);
    kick(0, 8'h10);
    step(12);
    kick(0, 8'hFE);
    step(4);
    start_a = 1'b1;
    base_a  = 8'h40;
    step(1);
    start_a = 1'b0;
    step(7);
    kick(0, 8'h20);
    step(11);
    start_a = 1'b1;
    base_a  = 8'h80;
    step(1);
    start_a = 1'b0;
    kick(0, 8'h30);
    step(7);
    rst_a = 1'b1;
    while (sb_a.size() > 0 && sb_a[sb_a.size()-1].cyc > cyc) sb_a.delete(sb_a.size() - 1);
    step(1);
    rst_a = 1'b0;
    step(1);
    kick(0, 8'h50);
    step(14);
    kick(1, 8'h10);
    step(10);
    kick(1, 8'hFF);
    step(4);
    start_b = 1'b1;
    base_b  = 8'h70;
    step(1);
    start_b = 1'b0;
    step(8);
    check("sb_a_drain", 64'(sb_a.size()), 64'd0);
    check("sb_b_drain", 64'(sb_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
